// File: rtl/midi_tx_encoder.sv
// Outbound MIDI encoder: event FIFO, channel-voice message framing and a 31250-baud UART.
// Optional running status is enabled by defining MIDI_TX_RUNNING_STATUS_EN.
module midi_tx_encoder #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg_N,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_status,
  input  logic [6:0] ev_data1,
  input  logic [6:0] ev_data2,
  output logic       midi_txd,
  output logic       busy,
  output logic       err
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] d1;
    logic [6:0] d2;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_STATUS, S_D1, S_D2} state_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              push, pop;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [8:0]        tx_shift;
  logic [6:0]        cur_d1, cur_d2;
  logic              cur_three;

  logic              head_valid, head_three, skip_status;

  assign push = ev_valid & ev_ready;
  assign pop  = (state == S_POP);
  assign head = mem[rd_ptr];

  assign head_valid = head.status[7] && (head.status[6:4] != 3'b111);
  assign head_three = (head.status[7:4] != 4'hC) && (head.status[7:4] != 4'hD);

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: payload storage has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge CLOCK_25) begin
    if (push) mem[wr_ptr] <= '{status: ev_status, d1: ev_data1, d2: ev_data2};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      ev_ready <= (count_next < CNT_FULL);
      busy     <= (count != '0) || (state != S_IDLE);
    end
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic       rs_valid;
  logic [7:0] rs_status;

  assign skip_status = rs_valid && (rs_status == head.status);

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rs_valid  <= 1'b0;
      rs_status <= '0;
    end else if (pop && head_valid && !skip_status) begin
      rs_valid  <= 1'b1;
      rs_status <= head.status;
    end
  end
`else
  assign skip_status = 1'b0;
`endif

  // tx_shift holds the bits still to send after the start bit: data LSB first, then stop.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state     <= S_IDLE;
      midi_txd  <= 1'b1;
      err       <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '1;
      cur_d1    <= '0;
      cur_d2    <= '0;
      cur_three <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_POP;
            err   <= ~head_valid;
          end
        end
        S_POP: begin
          cur_d1    <= head.d1;
          cur_d2    <= head.d2;
          cur_three <= head_three;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          if (!head_valid) begin
            state <= S_IDLE;
          end else if (skip_status) begin
            state    <= S_D1;
            midi_txd <= 1'b0;
            tx_shift <= {2'b10, head.d1};
          end else begin
            state    <= S_STATUS;
            midi_txd <= 1'b0;
            tx_shift <= {1'b1, head.status};
          end
        end
        default: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end else begin
            baud_cnt <= '0;
            if (bit_cnt != STOP_BIT) begin
              bit_cnt  <= bit_cnt + 4'd1;
              midi_txd <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
            end else begin
              // Stop bit done: chain straight into the next byte's start bit.
              bit_cnt <= '0;
              if (state == S_STATUS) begin
                state    <= S_D1;
                midi_txd <= 1'b0;
                tx_shift <= {2'b10, cur_d1};
              end else if (state == S_D1 && cur_three) begin
                state    <= S_D2;
                midi_txd <= 1'b0;
                tx_shift <= {2'b10, cur_d2};
              end else begin
                state    <= S_IDLE;
                midi_txd <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Randomized bench for midi_tx_encoder: a message-level model predicts line bytes and errors,
// a UART monitor decodes midi_txd. Honors MIDI_TX_RUNNING_STATUS_EN like the design.
module tb_midi_tx_encoder;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int BUDGET = 5000;

  logic       CLOCK_25;
  logic       reset_reg_N;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_status;
  logic [6:0] ev_data1;
  logic [6:0] ev_data2;
  logic       midi_txd;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;
  int err_seen = 0;

  logic [7:0] exp_q[$];
  bit         rs_valid = 1'b0;
  logic [7:0] rs_val   = '0;

  midi_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
    .CLOCK_25   (CLOCK_25),
    .reset_reg_N(reset_reg_N),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_status  (ev_status),
    .ev_data1   (ev_data1),
    .ev_data2   (ev_data2),
    .midi_txd   (midi_txd),
    .busy       (busy),
    .err        (err)
  );

  initial begin
    CLOCK_25 = 1'b0;
    forever #5 CLOCK_25 = ~CLOCK_25;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Message-level reference: what bytes a single accepted event puts on the line.
  function automatic void model_accept(input logic [7:0] s, input logic [6:0] a,
                                       input logic [6:0] b);
    bit ok  = (s >= 8'h80) && (s < 8'hF0);
    bit two = (s >= 8'hC0) && (s < 8'hE0);
    if (!ok) begin
      exp_err++;
      return;
    end
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (!(rs_valid && rs_val == s)) begin
      exp_q.push_back(s);
      rs_valid = 1'b1;
      rs_val   = s;
    end
`else
    exp_q.push_back(s);
`endif
    exp_q.push_back({1'b0, a});
    if (!two) exp_q.push_back({1'b0, b});
  endfunction

  task automatic send_event(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
    int waited = 0;
    ev_status = s;
    ev_data1  = a;
    ev_data2  = b;
    ev_valid  = 1'b1;
    @(negedge CLOCK_25);
    while (!ev_ready && waited < BUDGET) begin
      @(negedge CLOCK_25);
      waited++;
    end
    if (waited >= BUDGET) begin
      check("accept_timeout", waited, 0);
      ev_valid = 1'b0;
      return;
    end
    @(posedge CLOCK_25);
    model_accept(s, a, b);
    #1 ev_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    repeat (4) @(negedge CLOCK_25);
    while ((busy || exp_q.size() != 0) && n < BUDGET) begin
      @(negedge CLOCK_25);
      n++;
    end
    check({tag, "_drain"}, (n < BUDGET), 1);
    check({tag, "_pending"}, exp_q.size(), 0);
    repeat (12) @(negedge CLOCK_25);
    check({tag, "_err_count"}, err_seen, exp_err);
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic rx_wait(input int n, inout bit ab);
    for (int k = 0; k < n && !ab; k++) begin
      @(negedge CLOCK_25);
      if (!reset_reg_N) ab = 1'b1;
    end
  endtask

  // UART receiver sampling mid-bit; any drift in bit length shifts samples off their bits.
  initial begin : rx_monitor
    bit         prev;
    bit         ab;
    logic [7:0] rx;
    logic       start_s, stop_s;
    prev = 1'b1;
    forever begin
      @(negedge CLOCK_25);
      if (!reset_reg_N) begin
        prev = 1'b1;
      end else if (prev && !midi_txd) begin
        ab = 1'b0;
        rx = '0;
        rx_wait(DIV / 2, ab);
        start_s = midi_txd;
        for (int b = 0; b < 8; b++) begin
          rx_wait(DIV, ab);
          rx[b] = midi_txd;
        end
        rx_wait(DIV, ab);
        stop_s = midi_txd;
        if (!ab) begin
          check("rx_start", start_s, 1'b0);
          check("rx_stop", stop_s, 1'b1);
          check("rx_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("rx_byte", rx, exp_q.pop_front());
        end
        prev = ab ? 1'b1 : midi_txd;
      end else begin
        prev = midi_txd;
      end
    end
  end

  initial begin : err_monitor
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge CLOCK_25);
      if (reset_reg_N && err) begin
        err_seen++;
        check("err_single_cycle", err_prev, 1'b0);
      end
      err_prev = reset_reg_N ? err : 1'b0;
    end
  end

  initial begin : main
    logic [7:0] pool [8] = '{8'h90, 8'h90, 8'hC3, 8'hD1, 8'hE0, 8'h8F, 8'h45, 8'hF8};
    logic [7:0] s;
    int         acc;
    int         n;

    reset_reg_N = 1'b0;
    ev_valid    = 1'b0;
    ev_status   = '0;
    ev_data1    = '0;
    ev_data2    = '0;
    repeat (3) @(negedge CLOCK_25);
    check("reset_txd", midi_txd, 1'b1);
    check("reset_ready", ev_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    reset_reg_N = 1'b1;
    @(posedge CLOCK_25);
    #1;

    // Single 3-byte message: start bit two cycles after acceptance, busy drops 3*10*DIV+1 later.
    send_event(8'h90, 7'h3C, 7'h64);
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check("txd_idle_in_pop", midi_txd, 1'b1);
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check("txd_start_edge", midi_txd, 1'b0);
    repeat (30 * DIV) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check("busy_before_end", busy, 1'b1);
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check("busy_after_end", busy, 1'b0);
    drain("single");

    // Repeated status: running status drops the second status byte when enabled.
    send_event(8'h90, 7'h3C, 7'h64);
    send_event(8'h90, 7'h3E, 7'h40);
    drain("rs_note");
    send_event(8'hC5, 7'h07, 7'h55);
    send_event(8'hC5, 7'h09, 7'h00);
    drain("rs_prog");

    // Burst: valid held six cycles, FIFO fills after five acceptances.
    acc = 0;
    ev_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ev_status = (i % 2 == 0) ? 8'hB1 : 8'hE2;
      ev_data1  = 7'($urandom);
      ev_data2  = 7'($urandom);
      @(negedge CLOCK_25);
      if (ev_ready) begin
        acc++;
        @(posedge CLOCK_25);
        model_accept(ev_status, ev_data1, ev_data2);
      end else begin
        @(posedge CLOCK_25);
      end
      #1;
    end
    ev_valid = 1'b0;
    check("burst_accepts", acc, 5);
    n = 0;
    @(negedge CLOCK_25);
    while (!ev_ready && n < BUDGET) begin
      @(negedge CLOCK_25);
      n++;
    end
    check("burst_ready_return", ev_ready, 1'b1);
    @(posedge CLOCK_25);
    #1;
    drain("burst");

    // Invalid status: popped and flagged in its POP cycle, nothing sent, status memory kept.
    send_event(8'h80, 7'h11, 7'h22);
    drain("inv_pre");
    send_event(8'h45, 7'h01, 7'h02);
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check("err_in_pop", err, 1'b1);
    @(negedge CLOCK_25);
    check("err_clears", err, 1'b0);
    check("inv_no_line", midi_txd, 1'b1);
    @(posedge CLOCK_25);
    #1;
    send_event(8'h80, 7'h3C, 7'h00);
    send_event(8'hF8, 7'h05, 7'h06);
    drain("invalid");

    // Randomized traffic with a status pool that exercises repeats, 2-byte and invalid codes.
    for (int i = 0; i < 30; i++) begin
      s = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) s = 8'($urandom);
      send_event(s, 7'($urandom), 7'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_25);
      #1;
    end
    drain("random");

    // Reset mid data bit, then the same status must go out in full.
    send_event(8'h90, 7'h3C, 7'h64);
    drain("pre_reset");
    send_event(8'h90, 7'h11, 7'h22);
    repeat (4 * DIV + DIV / 2) @(posedge CLOCK_25);
    #3 reset_reg_N = 1'b0;
    exp_q.delete();
    rs_valid = 1'b0;
    #1;
    check("midreset_txd", midi_txd, 1'b1);
    check("midreset_ready", ev_ready, 1'b1);
    check("midreset_busy", busy, 1'b0);
    repeat (3) @(negedge CLOCK_25);
    reset_reg_N = 1'b1;
    @(posedge CLOCK_25);
    #1;
    send_event(8'h90, 7'h3C, 7'h64);
    check("post_reset_bytes", exp_q.size(), 3);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
